// File: rtl/usb_rx_crc16_ctrl.sv
// USB receive-side CRC16 sequencer: PID check, CRC engine feed, CRC-byte stripping, per-packet verdict.
// Optional feature macro: USB_RX_CRC_STATS_EN adds saturating stat_good/stat_bad verdict counters.
module usb_rx_crc16_ctrl #(
  parameter int MAX_PAYLOAD = 1023,
  parameter int CNT_W       = 11
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [7:0]       rx_byte,
  input  logic             rx_byte_valid,
  input  logic             rx_sop,
  input  logic             rx_eop,
  input  logic             crc_valid,
  output logic             crc_init,
  output logic             crc_en,
  output logic [7:0]       crc_data,
  output logic [7:0]       pld_byte,
  output logic             pld_valid,
  output logic [3:0]       pid_out,
  output logic             pkt_done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             len_err,
  output logic [CNT_W-1:0] pld_len
`ifdef USB_RX_CRC_STATS_EN
  ,
  output logic [15:0]      stat_good,
  output logic [15:0]      stat_bad
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PID   = 3'd1,
    S_DATA  = 3'd2,
    S_WAIT  = 3'd3,
    S_CHECK = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PAYLOAD);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_PAYLOAD + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic pid_chk(input logic [7:0] b);
    return (b[3:0] == ~b[7:4]);
  endfunction

  function automatic logic pid_is_data(input logic [7:0] b);
    logic hit;
    case (b)
      8'hC3, 8'h4B, 8'h87, 8'h0F: hit = 1'b1;
      default:                    hit = 1'b0;
    endcase
    return hit && pid_chk(b);
  endfunction

  state_t           state_q, state_d;
  logic [7:0]       hold0_q, hold0_d, hold1_q, hold1_d;
  logic [1:0]       fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       pid_q, pid_d;
  logic             crc_init_q, crc_init_d, crc_en_q, crc_en_d;
  logic [7:0]       crc_data_q, crc_data_d, pld_byte_q, pld_byte_d;
  logic             pld_valid_q, pld_valid_d, pkt_done_q, pkt_done_d;
  logic             crc_ok_q, crc_ok_d, crc_err_q, crc_err_d, len_err_q, len_err_d;
  logic [CNT_W-1:0] pld_len_q, pld_len_d;
  logic             len_err_s;

  // Next-state logic; rx_sop in any state restarts the packet ahead of everything else.
  always_comb begin
    state_d     = state_q;
    hold0_d     = hold0_q;
    hold1_d     = hold1_q;
    fill_d      = fill_q;
    cnt_d       = cnt_q;
    pid_d       = pid_q;
    crc_init_d  = 1'b0;
    crc_en_d    = 1'b0;
    crc_data_d  = crc_data_q;
    pld_byte_d  = pld_byte_q;
    pld_valid_d = 1'b0;
    pkt_done_d  = 1'b0;
    crc_ok_d    = 1'b0;
    crc_err_d   = 1'b0;
    len_err_d   = 1'b0;
    pld_len_d   = pld_len_q;
    len_err_s   = 1'b0;
    if (rx_sop) begin
      state_d    = S_PID;
      crc_init_d = 1'b1;
      fill_d     = 2'd0;
      cnt_d      = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_PID: begin
          if (rx_byte_valid) begin
            if (pid_is_data(rx_byte)) begin
              state_d = S_DATA;
              pid_d   = rx_byte[3:0];
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_PID;
          end
        end
        S_DATA: begin
          if (rx_byte_valid) begin
            crc_en_d   = 1'b1;
            crc_data_d = rx_byte;
            hold0_d    = rx_byte;
            hold1_d    = hold0_q;
            // Only a full pipe releases a byte: the last two held are the CRC.
            if (fill_q == 2'd2) begin
              pld_byte_d  = hold1_q;
              pld_valid_d = 1'b1;
              if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CNT_ONE;
              end else begin
                cnt_d = cnt_q;
              end
            end else begin
              fill_d = fill_q + 2'd1;
            end
          end else begin
            crc_en_d = 1'b0;
          end
          if (rx_eop) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_DATA;
          end
        end
        S_WAIT: state_d = S_CHECK;
        S_CHECK: begin
          len_err_s  = (fill_q != 2'd2) || (cnt_q > CNT_MAX);
          pkt_done_d = 1'b1;
          len_err_d  = len_err_s;
          crc_ok_d   = crc_valid & ~len_err_s;
          crc_err_d  = ~crc_valid & ~len_err_s;
          pld_len_d  = cnt_q;
          state_d    = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      hold0_q     <= 8'h00;
      hold1_q     <= 8'h00;
      fill_q      <= 2'd0;
      cnt_q       <= {CNT_W{1'b0}};
      pid_q       <= 4'h0;
      crc_init_q  <= 1'b0;
      crc_en_q    <= 1'b0;
      crc_data_q  <= 8'h00;
      pld_byte_q  <= 8'h00;
      pld_valid_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      crc_ok_q    <= 1'b0;
      crc_err_q   <= 1'b0;
      len_err_q   <= 1'b0;
      pld_len_q   <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      hold0_q     <= hold0_d;
      hold1_q     <= hold1_d;
      fill_q      <= fill_d;
      cnt_q       <= cnt_d;
      pid_q       <= pid_d;
      crc_init_q  <= crc_init_d;
      crc_en_q    <= crc_en_d;
      crc_data_q  <= crc_data_d;
      pld_byte_q  <= pld_byte_d;
      pld_valid_q <= pld_valid_d;
      pkt_done_q  <= pkt_done_d;
      crc_ok_q    <= crc_ok_d;
      crc_err_q   <= crc_err_d;
      len_err_q   <= len_err_d;
      pld_len_q   <= pld_len_d;
    end
  end

  assign crc_init  = crc_init_q;
  assign crc_en    = crc_en_q;
  assign crc_data  = crc_data_q;
  assign pld_byte  = pld_byte_q;
  assign pld_valid = pld_valid_q;
  assign pid_out   = pid_q;
  assign pkt_done  = pkt_done_q;
  assign crc_ok    = crc_ok_q;
  assign crc_err   = crc_err_q;
  assign len_err   = len_err_q;
  assign pld_len   = pld_len_q;

`ifdef USB_RX_CRC_STATS_EN
  logic [15:0] stat_good_q, stat_bad_q;

  // Verdict counters, saturating, updated the cycle after pkt_done.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stat_good_q <= 16'h0000;
      stat_bad_q  <= 16'h0000;
    end else begin
      if (pkt_done_q && crc_ok_q && (stat_good_q != 16'hFFFF)) begin
        stat_good_q <= stat_good_q + 16'd1;
      end
      if (pkt_done_q && (crc_err_q || len_err_q) && (stat_bad_q != 16'hFFFF)) begin
        stat_bad_q <= stat_bad_q + 16'd1;
      end
    end
  end

  assign stat_good = stat_good_q;
  assign stat_bad  = stat_bad_q;
`endif

endmodule

// File: tb/tb_usb_rx_crc16_ctrl.sv
// Scoreboard bench for usb_rx_crc16_ctrl with a small CRC16 engine model and randomized packets.
module tb_usb_rx_crc16_ctrl;

  localparam int MAXP = 4;
  localparam int CW   = 3;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic          ok;
    logic          err;
    logic          lerr;
    logic [CW-1:0] len;
    logic [3:0]    pid;
  } verd_t;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [7:0]    rx_byte;
  logic          rx_byte_valid, rx_sop, rx_eop;
  logic          crc_valid = 1'b0;
  logic          crc_init, crc_en, pld_valid, pkt_done, crc_ok, crc_err, len_err;
  logic [7:0]    crc_data, pld_byte;
  logic [3:0]    pid_out;
  logic [CW-1:0] pld_len;
`ifdef USB_RX_CRC_STATS_EN
  logic [15:0]   stat_good, stat_bad;
`endif

  usb_rx_crc16_ctrl #(.MAX_PAYLOAD(MAXP), .CNT_W(CW)) dut (
    .clk(clk), .n_rst(n_rst), .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid),
    .rx_sop(rx_sop), .rx_eop(rx_eop), .crc_valid(crc_valid),
    .crc_init(crc_init), .crc_en(crc_en), .crc_data(crc_data),
    .pld_byte(pld_byte), .pld_valid(pld_valid), .pid_out(pid_out),
    .pkt_done(pkt_done), .crc_ok(crc_ok), .crc_err(crc_err), .len_err(len_err),
    .pld_len(pld_len)
`ifdef USB_RX_CRC_STATS_EN
    , .stat_good(stat_good), .stat_bad(stat_bad)
`endif
  );

  always #5 clk = ~clk;

  int    checks = 0, errors = 0;
  int    n_en = 0, n_init = 0, exp_en = 0, exp_init = 0;
  int    exp_good = 0, exp_bad = 0;
  bq_t   exp_pld;
  verd_t exp_verd[$];
  bq_t   eng_q;

  // USB CRC16: reflected poly 0xA001, seed 0xFFFF, inverted, sent low byte first.
  function automatic logic [15:0] crc16(input bq_t d, input int n);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {8'h00, d[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic logic good_crc(input bq_t d);
    int n = d.size();
    logic [15:0] c;
    if (n < 2) return 1'b0;
    c = crc16(d, n - 2);
    return (c == {d[n-1], d[n-2]});
  endfunction

  function automatic bq_t with_crc(input bq_t pl);
    bq_t d = pl;
    logic [15:0] c = crc16(pl, pl.size());
    d.push_back(c[7:0]);
    d.push_back(c[15:8]);
    return d;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t d;
    for (int i = 0; i < n; i++) d.push_back(8'($urandom));
    return d;
  endfunction

  // CRC engine model: reseeds on crc_init, records every byte fed, flags a good residue.
  always @(negedge clk) begin
    if (!n_rst) begin
      eng_q.delete();
      crc_valid = 1'b0;
    end else begin
      if (crc_init) eng_q.delete();
      if (crc_en) eng_q.push_back(crc_data);
      crc_valid = good_crc(eng_q);
    end
  end

  // Monitor: pops expectations whenever the DUT presents payload or a verdict.
  always @(negedge clk) begin
    logic [7:0] e;
    verd_t v, a;
    if (n_rst) begin
      if (crc_en) n_en++;
      if (crc_init) n_init++;
      if (pld_valid) begin
        checks++;
        if (exp_pld.size() == 0) begin
          errors++;
          $display("FAIL pld_unexpected got %02h expected nothing", pld_byte);
        end else begin
          e = exp_pld.pop_front();
          if (pld_byte !== e) begin
            errors++;
            $display("FAIL pld_byte got %02h expected %02h", pld_byte, e);
          end
        end
      end
      if (pkt_done) begin
        checks++;
        a = {crc_ok, crc_err, len_err, pld_len, pid_out};
        if (exp_verd.size() == 0) begin
          errors++;
          $display("FAIL verdict_unexpected got ok=%0b err=%0b lerr=%0b len=%0d", crc_ok, crc_err, len_err, pld_len);
        end else begin
          v = exp_verd.pop_front();
          if (a !== v) begin
            errors++;
            $display("FAIL verdict got ok=%0b err=%0b lerr=%0b len=%0d pid=%h expected ok=%0b err=%0b lerr=%0b len=%0d pid=%h",
                     a.ok, a.err, a.lerr, a.len, a.pid, v.ok, v.err, v.lerr, v.len, v.pid);
          end
        end
      end
    end
  end

  task automatic drive(input logic s, input logic v, input logic [7:0] b, input logic e);
    rx_sop = s; rx_byte_valid = v; rx_byte = b; rx_eop = e;
    @(posedge clk); #1;
    rx_sop = 1'b0; rx_byte_valid = 1'b0; rx_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk_zero(input string name);
    logic [40:0] act;
    act = {crc_init, crc_en, crc_data, pld_byte, pld_valid, pid_out, pkt_done,
           crc_ok, crc_err, len_err, pld_len, 9'h000};
`ifdef USB_RX_CRC_STATS_EN
    act = act | {25'h0, stat_good | stat_bad};
`endif
    checks++;
    if (act !== 41'h0) begin
      errors++;
      $display("FAIL %s outputs got %h expected 0", name, act);
    end
  endtask

  // One packet: SOP, PID, bytes; abort=1 leaves it open for the next SOP to cut off.
  task automatic send_pkt(input logic [7:0] pid, input bq_t d, input bit abort);
    int n = d.size();
    bit is_data = (pid == 8'hC3) || (pid == 8'h4B) || (pid == 8'h87) || (pid == 8'h0F);
    bit eop_last = 1'($urandom);
    int pl, cl;
    bit lerr, g;
    exp_init++;
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0, 8'h00, 1'b1);
    idle($urandom_range(0, 2));
    drive(1'b0, 1'b1, pid, 1'b0);
    if (!is_data) begin
      drive(1'b0, 1'b1, 8'($urandom), 1'b0);
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      idle(3);
      return;
    end
    for (int i = 0; i < n; i++) begin
      if (i >= 2) exp_pld.push_back(d[i-2]);
      exp_en++;
      drive(1'b0, 1'b1, d[i], (i == n - 1) && !abort && eop_last);
      if ((i != n - 1) && ($urandom_range(0, 3) == 0)) idle(1);
    end
    if (abort) return;
    if ((n == 0) || !eop_last) drive(1'b0, 1'b0, 8'h00, 1'b1);
    pl   = n - 2;
    lerr = (n < 2) || (pl > MAXP);
    cl   = (n < 2) ? 0 : ((pl > MAXP + 1) ? MAXP + 1 : pl);
    g    = good_crc(d);
    exp_verd.push_back({g && !lerr, !g && !lerr, lerr, CW'(cl), pid[3:0]});
    if (g && !lerr) exp_good++; else exp_bad++;
    idle(4);
  endtask

  initial begin
    bq_t d;
    logic [7:0] dpids[4] = '{8'hC3, 8'h4B, 8'h87, 8'h0F};
    logic [7:0] npids[5] = '{8'h69, 8'hE1, 8'h2D, 8'hD2, 8'h5A};
    n_rst = 1'b0; rx_byte = 8'h00; rx_byte_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0;
    #23;
    chk_zero("reset");
    n_rst = 1'b1;
    @(posedge clk); #1;

    // Async reset in the middle of a packet.
    exp_init++;
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 8'hC3, 1'b0);
    drive(1'b0, 1'b1, 8'h11, 1'b0);
    drive(1'b0, 1'b1, 8'h22, 1'b0);
    exp_en += 2;
    idle(1);
    n_rst = 1'b0;
    #2;
    chk_zero("mid_reset");
    @(posedge clk); #1;
    n_rst = 1'b1;
    idle(2);

    d = with_crc('{8'h00, 8'h01, 8'h02, 8'h03});
    send_pkt(8'hC3, d, 1'b0);
    d[5] = d[5] ^ 8'h01;
    send_pkt(8'hC3, d, 1'b0);
    send_pkt(8'h4B, '{8'h5A}, 1'b0);
    send_pkt(8'h4B, with_crc('{}), 1'b0);
    send_pkt(8'hC4, '{}, 1'b0);
    send_pkt(8'h69, '{}, 1'b0);
    send_pkt(8'h87, '{8'h10, 8'h20, 8'h30, 8'h40}, 1'b1);
    send_pkt(8'h87, with_crc('{8'hAA, 8'h55}), 1'b0);
    send_pkt(8'h0F, with_crc('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05}), 1'b0);
    send_pkt(8'hC3, with_crc(rand_bytes(MAXP)), 1'b0);
    send_pkt(8'hC3, with_crc(rand_bytes(MAXP + 2)), 1'b0);

    for (int t = 0; t < 40; t++) begin
      int kind = $urandom_range(0, 9);
      logic [7:0] p;
      if (kind == 0) begin
        p = 8'($urandom);
        if (p[3:0] == ~p[7:4]) p = p ^ 8'h01;
        send_pkt(p, '{}, 1'b0);
      end else if (kind == 1) begin
        send_pkt(npids[$urandom_range(0, 4)], '{}, 1'b0);
      end else if (kind == 2) begin
        send_pkt(dpids[$urandom_range(0, 3)], rand_bytes($urandom_range(0, 5)), 1'b1);
        send_pkt(dpids[$urandom_range(0, 3)], with_crc(rand_bytes($urandom_range(0, 3))), 1'b0);
      end else if (kind == 3) begin
        send_pkt(dpids[$urandom_range(0, 3)], rand_bytes($urandom_range(0, 1)), 1'b0);
      end else begin
        d = with_crc(rand_bytes($urandom_range(0, MAXP + 2)));
        if ($urandom_range(0, 3) == 0) begin
          int j = $urandom_range(0, d.size() - 1);
          d[j] = d[j] ^ 8'(1 << $urandom_range(0, 7));
        end
        send_pkt(dpids[$urandom_range(0, 3)], d, 1'b0);
      end
    end

    for (int k = 0; (k < 100) && ((exp_pld.size() != 0) || (exp_verd.size() != 0)); k++) idle(1);
    idle(3);
    checks++;
    if ((exp_pld.size() != 0) || (exp_verd.size() != 0)) begin
      errors++;
      $display("FAIL drain pending pld=%0d verdicts=%0d expected 0", exp_pld.size(), exp_verd.size());
    end
    checks++;
    if (n_en != exp_en) begin
      errors++;
      $display("FAIL crc_en_count got %0d expected %0d", n_en, exp_en);
    end
    checks++;
    if (n_init != exp_init) begin
      errors++;
      $display("FAIL crc_init_count got %0d expected %0d", n_init, exp_init);
    end
`ifdef USB_RX_CRC_STATS_EN
    checks++;
    if ((stat_good != 16'(exp_good)) || (stat_bad != 16'(exp_bad))) begin
      errors++;
      $display("FAIL stats got good=%0d bad=%0d expected good=%0d bad=%0d", stat_good, stat_bad, exp_good, exp_bad);
    end
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
